// File: rtl/div_nr_32_pkg.sv
// Shared definitions for the non-restoring divider: FSM state encoding and default width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_nr_32_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // IDLE -> PREP -> ITER (xWIDTH) -> FIX -> DONE -> IDLE
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } div_state_t;

endpackage

// File: rtl/div_nr_32_addsub.sv
// Combinational N-bit ripple add/subtract: y = sub ? a - b : a + b (two's complement).
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
//
// Ports:
//   a, b : N-bit operands
//   sub  : 1 selects a - b (b inverted, carry-in 1); 0 selects a + b
//   y    : N-bit result, carry-out discarded (callers size N so the true result fits)
module addsub_nr #(
    parameter int N = 33
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] y
);

    logic [N-1:0] bx;
    logic [N-1:0] c;

    assign bx   = b ^ {N{sub}};
    assign c[0] = sub;

    // One full-adder cell per bit; the carry out of the top cell is never needed.
    for (genvar i = 0; i < N; i++) begin : g_fa
        assign y[i] = a[i] ^ bx[i] ^ c[i];
        if (i < N - 1) begin : g_carry
            assign c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
        end
    end

endmodule

// File: rtl/div_nr_32.sv
// Multi-cycle signed/unsigned non-restoring divider, one quotient bit per clock.
// Latency: start accepted at edge k -> done high after edge k+WIDTH+2; divide-by-zero after edge k+2.
// Backpressure: start only sampled in IDLE; ignored while busy or during the done cycle.
//
// Ports:
//   clock, clear            : clock and asynchronous active-high reset
//   start, dividend, divisor: request and operands, captured on the accepting edge
//   busy                    : high in PREP, ITER and FIX
//   done                    : one-cycle pulse; quotient/remainder/div_by_zero valid from then on
//   quotient, remainder     : registered results, held until the next done
//   div_by_zero             : registered flag, held until the next done
module div_nr_32
    import div_nr_32_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter bit SIGNED = 1'b1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int            CW        = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    div_state_t       state;
    logic [WIDTH-1:0] a_q;       // raw dividend as captured
    logic [WIDTH-1:0] b_q;       // raw divisor as captured
    logic [WIDTH-1:0] q_r;       // dividend magnitude shifting out, quotient bits shifting in
    logic [WIDTH:0]   p_r;       // signed partial remainder, one guard bit
    logic [WIDTH:0]   d_r;       // divisor magnitude, zero-extended
    logic [CW-1:0]    count;
    logic             sign_q;
    logic             sign_r;
    logic             dz_r;

    // Operand magnitudes. -x of the most negative value wraps to itself, which is the
    // correct unsigned magnitude 2^(WIDTH-1).
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;

    assign a_neg = SIGNED & a_q[WIDTH-1];
    assign b_neg = SIGNED & b_q[WIDTH-1];
    assign a_abs = a_neg ? -a_q : a_q;
    assign b_abs = b_neg ? -b_q : b_q;

    // One adder serves both the iteration step (on the shifted remainder) and the final
    // correction in FIX (on the unshifted remainder, always an add).
    logic [WIDTH:0] p_sh;
    logic [WIDTH:0] as_a;
    logic [WIDTH:0] as_y;
    logic           as_sub;

    assign p_sh   = {p_r[WIDTH-1:0], q_r[WIDTH-1]};
    assign as_a   = (state == ST_FIX) ? p_r : p_sh;
    assign as_sub = (state == ST_ITER) & ~p_r[WIDTH];

    addsub_nr #(
        .N (WIDTH + 1)
    ) u_addsub (
        .a   (as_a),
        .b   (d_r),
        .sub (as_sub),
        .y   (as_y)
    );

    // Result shaping in FIX: restore a negative remainder, then apply signs.
    logic [WIDTH-1:0] r_mag;
    logic [WIDTH-1:0] q_res;
    logic [WIDTH-1:0] r_res;

    assign r_mag = p_r[WIDTH] ? as_y[WIDTH-1:0] : p_r[WIDTH-1:0];
    assign q_res = sign_q ? -q_r : q_r;
    assign r_res = sign_r ? -r_mag : r_mag;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state       <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            q_r         <= '0;
            p_r         <= '0;
            d_r         <= '0;
            count       <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            dz_r        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            busy <= 1'b0;
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_q   <= dividend;
                        b_q   <= divisor;
                        busy  <= 1'b1;
                        state <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    sign_q <= a_neg ^ b_neg;
                    sign_r <= a_neg;
                    q_r    <= a_abs;
                    d_r    <= {1'b0, b_abs};
                    p_r    <= '0;
                    count  <= '0;
                    dz_r   <= (b_q == '0);
                    busy   <= 1'b1;
                    // A zero divisor skips the iterations; FIX still registers the
                    // outputs so every result leaves through the same output stage.
                    state  <= (b_q == '0) ? ST_FIX : ST_ITER;
                end
                ST_ITER: begin
                    p_r   <= as_y;
                    q_r   <= {q_r[WIDTH-2:0], ~as_y[WIDTH]};
                    count <= count + CW'(1);
                    busy  <= 1'b1;
                    if (count == LAST_STEP) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (dz_r) begin
                        quotient    <= '1;
                        remainder   <= a_q;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient    <= q_res;
                        remainder   <= r_res;
                        div_by_zero <= 1'b0;
                    end
                    done  <= 1'b1;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_nr_32.sv
// Self-checking bench for div_nr_32: directed cases plus randomized back-to-back streams.
// Latency: checks accept-to-done timing and done-to-done spacing with start held high.
// Backpressure: checks that start is ignored while busy.
module tb_div_nr_32;

    logic        clk;
    logic        clear;

    // Signed instance
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    // Unsigned instance
    logic        u_start;
    logic [31:0] u_dividend;
    logic [31:0] u_divisor;
    logic        u_busy;
    logic        u_done;
    logic [31:0] u_quotient;
    logic [31:0] u_remainder;
    logic        u_div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    div_nr_32 #(.WIDTH(32), .SIGNED(1'b1)) u_dut (
        .clock       (clk),
        .clear       (clear),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    div_nr_32 #(.WIDTH(32), .SIGNED(1'b0)) u_dut_u (
        .clock       (clk),
        .clear       (clear),
        .start       (u_start),
        .dividend    (u_dividend),
        .divisor     (u_divisor),
        .busy        (u_busy),
        .done        (u_done),
        .quotient    (u_quotient),
        .remainder   (u_remainder),
        .div_by_zero (u_div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic. SV '/' truncates toward zero and '%' takes the
    // dividend's sign; 64-bit intermediates make -2^31 / -1 wrap to 0x80000000.
    function automatic void ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r, output logic dz);
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            q  = 32'hFFFF_FFFF;
            r  = a;
            dz = 1'b1;
        end else begin
            dz = 1'b0;
            if (sgn) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                q  = 32'(sa / sb);
                r  = 32'(sa % sb);
            end else begin
                q = a / b;
                r = a % b;
            end
        end
    endfunction

    function automatic void pick(output logic [31:0] a, output logic [31:0] b);
        int cls;
        cls = $urandom_range(0, 9);
        a   = $urandom;
        b   = $urandom;
        case (cls)
            4: b = ($urandom_range(0, 1) == 0) ? 32'd1 : 32'hFFFF_FFFF;
            5: a = 32'd0;
            6: begin
                b = 32'h4000_0000 | $urandom;
                a = 32'($urandom_range(0, 5000));
                if ($urandom_range(0, 1) == 1) a = -a;
            end
            7: b = 32'd0;
            8: begin
                a = 32'h8000_0000;
                if ($urandom_range(0, 1) == 1) b = 32'hFFFF_FFFF;
            end
            9: begin
                a = 32'($urandom_range(0, 400)) - 32'd200;
                b = 32'($urandom_range(1, 30));
                if ($urandom_range(0, 1) == 1) b = -b;
            end
            default: ;
        endcase
    endfunction

    task automatic drive(input bit u, input logic s, input logic [31:0] a, input logic [31:0] b);
        if (u) begin
            u_start = s; u_dividend = a; u_divisor = b;
        end else begin
            start = s; dividend = a; divisor = b;
        end
    endtask

    // One isolated operation: pulse start, count edges until done, track busy.
    task automatic do_op(input bit u, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic dz,
                         output int lat, output bit busy_ok);
        @(negedge clk);
        drive(u, 1'b1, a, b);
        @(posedge clk);
        #1;
        drive(u, 1'b0, a, b);
        busy_ok = u ? u_busy : busy;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (u ? u_done : done) break;
            if (!(u ? u_busy : busy)) busy_ok = 1'b0;
        end
        q  = u ? u_quotient : quotient;
        r  = u ? u_remainder : remainder;
        dz = u ? u_div_by_zero : div_by_zero;
        @(posedge clk);
    endtask

    task automatic dir_op(input string tag, input bit u, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input logic edz, input int elat);
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
        bit          bok;
        do_op(u, a, b, q, r, dz, lat, bok);
        check({tag, ".quotient"}, q, eq);
        check({tag, ".remainder"}, r, er);
        check({tag, ".div_by_zero"}, 32'(dz), 32'(edz));
        check({tag, ".latency"}, lat, elat);
        check({tag, ".busy"}, 32'(bok), 32'd1);
    endtask

    // start held high: each result is checked, and the edge count between dones must
    // show exactly one idle cycle between back-to-back operations.
    task automatic stream(input bit u, input int n);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eq;
        logic [31:0] er;
        logic        edz;
        int          cnt;
        int          base;
        pick(a, b);
        @(negedge clk);
        drive(u, 1'b1, a, b);
        for (int i = 0; i < n; i++) begin
            cnt = 0;
            do begin
                @(posedge clk);
                #1;
                cnt++;
            end while (!(u ? u_done : done) && cnt < 200);
            ref_div(!u, a, b, eq, er, edz);
            base = (i == 0) ? 1 : 2;
            check(u ? "stream_u.gap" : "stream_s.gap", cnt, base + (edz ? 2 : 34));
            if (cnt >= 200) break;
            check(u ? "stream_u.quotient" : "stream_s.quotient", u ? u_quotient : quotient, eq);
            check(u ? "stream_u.remainder" : "stream_s.remainder", u ? u_remainder : remainder, er);
            check(u ? "stream_u.div_by_zero" : "stream_s.div_by_zero",
                  32'(u ? u_div_by_zero : div_by_zero), 32'(edz));
            pick(a, b);
            drive(u, 1'b1, a, b);
        end
        drive(u, 1'b0, a, b);
    endtask

    initial begin
        int          ndone;
        logic [31:0] q_seen;
        logic [31:0] r_seen;

        clear = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 32'd0, 32'd0);
        #12;
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.quotient", quotient, 32'd0);
        check("reset.remainder", remainder, 32'd0);
        check("reset.div_by_zero", 32'(div_by_zero), 32'd0);
        check("reset.u_busy", 32'(u_busy), 32'd0);
        check("reset.u_quotient", u_quotient, 32'd0);
        @(negedge clk);
        clear = 1'b0;

        dir_op("pos_pos", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);
        dir_op("neg_pos", 1'b0, -32'd100, 32'd7, 32'hFFFF_FFF2, -32'd2, 1'b0, 34);
        dir_op("pos_neg", 1'b0, 32'd100, -32'd7, -32'd14, 32'd2, 1'b0, 34);
        dir_op("neg_neg", 1'b0, -32'd100, -32'd7, 32'd14, -32'd2, 1'b0, 34);
        dir_op("overflow", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 34);
        dir_op("unsigned_max", 1'b1, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1, 1'b0, 34);
        dir_op("unsigned_small", 1'b1, 32'd5, 32'hFFFF_FFFF, 32'd0, 32'd5, 1'b0, 34);
        dir_op("zero_dividend", 1'b0, 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 34);
        dir_op("small_dividend", 1'b0, 32'd3, -32'd10, 32'd0, 32'd3, 1'b0, 34);
        dir_op("div_by_one", 1'b0, -32'd7, 32'd1, -32'd7, 32'd0, 1'b0, 34);
        dir_op("div_zero", 1'b0, 32'd12345, 32'd0, 32'hFFFF_FFFF, 32'd12345, 1'b1, 2);
        dir_op("after_div_zero", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);

        // Asynchronous clear in the middle of the iterations.
        @(negedge clk);
        drive(1'b0, 1'b1, 32'd1000, 32'd3);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 32'd1000, 32'd3);
        repeat (11) @(posedge clk);
        #2;
        clear = 1'b1;
        #1;
        check("clear.busy", 32'(busy), 32'd0);
        check("clear.done", 32'(done), 32'd0);
        check("clear.quotient", quotient, 32'd0);
        check("clear.remainder", remainder, 32'd0);
        check("clear.div_by_zero", 32'(div_by_zero), 32'd0);
        check("clear.u_quotient", u_quotient, 32'd0);
        @(negedge clk);
        clear = 1'b0;
        dir_op("after_clear", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34);

        // start pulses while busy must not launch extra operations.
        @(negedge clk);
        drive(1'b0, 1'b1, 32'd50, 32'd5);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 32'd50, 32'd5);
        ndone  = 0;
        q_seen = '0;
        r_seen = '1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            drive(1'b0, (i % 4 == 1) && (i < 28), 32'(1000 + i), 32'd1);
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                q_seen = quotient;
                r_seen = remainder;
            end
        end
        drive(1'b0, 1'b0, 32'd0, 32'd1);
        check("ignore_start.done_count", ndone, 32'd1);
        check("ignore_start.quotient", q_seen, 32'd10);
        check("ignore_start.remainder", r_seen, 32'd0);

        repeat (3) @(posedge clk);
        fork
            stream(1'b0, 1200);
            stream(1'b1, 600);
        join

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
